data_memory: RTL
================

# data_memory

Word-organised data RAM directly downstream of the single-cycle datapath. It consumes the datapath's `alu_result` as the address and `write_data` as store data, and returns `read_data` combinationally in the same cycle so LDR/STR complete in one cycle. Stores commit on the rising clock edge. The block adds optional byte lanes for LDRB/STRB, a sticky access-fault flag, and a committed-store counter for debug and verification.

## Interface
Parameters:
- `ADDR_WIDTH`, default 6: word-address bits, giving 2^ADDR_WIDTH 32-bit words (64 words = 256 bytes).

Ports:
- `clk`  in  1: clock; rising edge active.
- `reset`  in  1: asynchronous, active-low reset.
- `mem_write`  in  1: store request this cycle.
- `byte_en`  in  1: byte access (LDRB/STRB); 0 selects word access.
- `addr`  in  32: byte address, driven from the datapath `alu_result`.
- `write_data`  in  32: store data; byte stores use bits [7:0].
- `fault_clear`  in  1: clears the sticky fault flag.
- `read_data`  out  32: load data, combinational.
- `fault`  out  1: sticky fault flag (misaligned or out-of-range access).
- `store_count`  out  16: count of committed stores; wraps modulo 2^16.

## Operation
- Storage is a flop array `mem[0 .. 2^ADDR_WIDTH-1]` of 32-bit words.
- Word index is `addr[ADDR_WIDTH+1:2]`. Byte lane is `addr[1:0]`, little-endian: lane 0 is bits [7:0].
- An address is out of range when `addr[31:ADDR_WIDTH+2]` is nonzero.
- An access is misaligned when `byte_en`=0 and `addr[1:0]` is nonzero.
- Word read returns `mem[index]`. For a misaligned address, the low address bits are ignored and the aligned word is returned.
- Byte read returns the selected lane, zero-extended to 32 bits.
- Out-of-range read returns `32'h0`.
- Word store: if in range and aligned, writes `write_data` to `mem[index]` at the edge.
- Byte store: writes `write_data[7:0]` into the selected lane only; the other three lanes are unchanged.
- A store that is faulting (misaligned or out of range) is suppressed. The array and `store_count` are not modified.
- Fault detection is evaluated for every cycle with `mem_write`=1 and every cycle with a valid read. Because there is no read-enable input, reads count as valid when `mem_write`=0 and `byte_en`=0 or 1.
  - Simplification: `fault` is set only on cycles where `mem_write`=1, or where an explicit load would be issued. Because no load strobe exists, fault is raised only by faulting stores.
- `fault` set/clear:
  - Set at the edge where a faulting store is presented.
  - Cleared at the edge where `fault_clear`=1.
  - If `fault_clear`=1 and a new faulting store occur in the same cycle, the set wins and `fault`=1.
- `store_count` increments by 1 per committed (non-suppressed) store. `16'hFFFF` wraps to `16'h0000`.

## Timing
- Reset (`reset`=0, asynchronous): all `mem` words, `fault`, and `store_count` clear to 0 immediately. `read_data` then reads 0 for every address.
- While `reset` is low, no store commits. A store presented on the edge at which reset is low is lost.
- Read latency is 0 cycles: `read_data` follows `addr`/`byte_en` combinationally.
- Read-during-write to the same word returns the old contents until the edge. The new contents are visible immediately after the edge.
- `fault` and `store_count` update only on rising edges, one cycle after the request is presented.

## Configuration
- `DATA_MEMORY_BYTE_ACCESS_EN` defined:
  - `byte_en` is honoured as described above.
- Not defined:
  - `byte_en` is ignored and treated as 0. All accesses are word accesses.
  - Any nonzero `addr[1:0]` on a store is a misaligned fault.
  - The byte-lane mux and per-lane write enables are not synthesised.

## Test plan
- Reset then read: drop `reset` low mid-cycle after writing `mem[2]`=`32'h1234`; release → `read_data` at addr 8 = 0, `store_count`=0, `fault`=0.
- Word store/load: store `32'h0000000F` at addr 32; next cycle read addr 32 → `32'h0000000F`, `store_count`=1. Same-cycle read before the edge returns 0.
- Byte lanes (macro defined):
  - Store `32'hAABBCCDD` at addr 4.
  - STRB `8'h11` at addr 6 → word at addr 4 = `32'hAA11CCDD`.
  - LDRB addr 7 → `32'h000000AA`.
- Misaligned store: word store `32'hDEAD` at addr 9 → `mem[2]` unchanged, `fault`=1 after the edge, `store_count` unchanged. Repeat with `fault_clear`=1 in the same cycle → `fault` stays 1. A lone `fault_clear` → `fault`=0.
- Out of range (ADDR_WIDTH=6): store at addr `32'h100` → suppressed, `fault`=1. Read of `32'h100` → 0.
- Counter wrap: 65536 committed stores → `store_count` returns to 0. Without the macro, STRB at addr 1 raises `fault` and does not write.

Source files
------------

// File: rtl/data_memory.sv
// Word-organised data RAM with combinational read, edge-committed stores,
// sticky fault flag and a committed-store counter. Byte lanes: DATA_MEMORY_BYTE_ACCESS_EN.
module data_memory #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        fault_clear,
  output logic [31:0] read_data,
  output logic        fault,
  output logic [15:0] store_count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][31:0]  mem_q;
  logic                    fault_q, fault_d;
  logic [15:0]             count_q, count_d;

  logic [ADDR_WIDTH-1:0]   idx;
  logic [1:0]              lane;
  logic                    byte_acc;
  logic                    oor, misaligned, store_fault, commit;
  logic [31:0]             word, wr_word;

  assign idx  = addr[ADDR_WIDTH+1:2];
  assign lane = addr[1:0];
  assign oor  = |addr[31:ADDR_WIDTH+2];
  assign word = mem_q[idx];

`ifdef DATA_MEMORY_BYTE_ACCESS_EN
  logic [3:0] lane_we;
  assign byte_acc = byte_en;

  // Byte stores replicate the low byte into the addressed lane only.
  always_comb begin
    lane_we = byte_acc ? (4'b0001 << lane) : 4'b1111;
    wr_word = word;
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) wr_word[i*8 +: 8] = byte_acc ? write_data[7:0] : write_data[i*8 +: 8];
    end
  end

  always_comb begin
    read_data = 32'h0;
    if (!oor) read_data = byte_acc ? {24'h0, word[{lane, 3'b000} +: 8]} : word;
  end
`else
  logic unused_byte_en;
  assign unused_byte_en = byte_en;
  assign byte_acc       = 1'b0;
  assign wr_word        = write_data;

  always_comb begin
    read_data = 32'h0;
    if (!oor) read_data = word;
  end
`endif

  assign misaligned  = !byte_acc && (lane != 2'b00);
  assign store_fault = mem_write && (oor || misaligned);
  assign commit      = mem_write && !oor && !misaligned;

  // A new faulting store takes priority over a simultaneous clear.
  always_comb begin
    fault_d = fault_q;
    if (fault_clear) fault_d = 1'b0;
    if (store_fault) fault_d = 1'b1;
    count_d = count_q + {15'h0, commit};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      fault_q <= 1'b0;
      count_q <= 16'h0;
    end else begin
      if (commit) mem_q[idx] <= wr_word;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign fault       = fault_q;
  assign store_count = count_q;
endmodule
